// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register in-flight write counters that gate decode issue.
// Optional macro SB_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue immediately.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [4:0]      rd,
    input  logic            rd_wr,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            stall,
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_v [NREG];
    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             byp1, byp2;
    logic             haz1, haz2, src_haz, sat_haz;
    logic             issue_fire;
    logic             err_q, err_d;

    assign cnt_v[0] = '0;
    assign busy[0]  = 1'b0;

    assign cnt_rs1 = cnt_v[rs1];
    assign cnt_rs2 = cnt_v[rs2];
    assign cnt_rd  = cnt_v[rd];
    assign cnt_wb  = cnt_v[wb_rd];

`ifdef SB_WB_BYPASS_EN
    // Register file writes through, so the final retiring write is visible to a reader in the same cycle.
    assign byp1 = wb_valid && (wb_rd == rs1) && (cnt_rs1 == CNT_ONE);
    assign byp2 = wb_valid && (wb_rd == rs2) && (cnt_rs2 == CNT_ONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign haz1    = rs1_used && (rs1 != 5'd0) && (cnt_rs1 != '0) && !byp1;
    assign haz2    = rs2_used && (rs2 != 5'd0) && (cnt_rs2 != '0) && !byp2;
    assign src_haz = haz1 || haz2;
    // A same-cycle writeback to rd frees a slot, so a saturated counter may still accept the issue.
    assign sat_haz = rd_wr && (rd != 5'd0) && (cnt_rd == CNT_MAX) && !(wb_valid && (wb_rd == rd));

    assign issue_ready = !src_haz && !sat_haz;
    assign stall       = issue_valid && !issue_ready;
    assign issue_fire  = issue_valid && issue_ready;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             busy_q;
            logic             inc, dec;

            assign inc = issue_fire && rd_wr && (rd == 5'(gi));
            assign dec = wb_valid && (wb_rd == 5'(gi)) && (cnt_q != '0);

            always_comb begin
                cnt_d = cnt_q;
                if (flush) begin
                    cnt_d = '0;
                end else if (inc && !dec) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (dec && !inc) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    busy_q <= (cnt_d != '0);
                end
            end

            assign cnt_v[gi] = cnt_q;
            assign busy[gi]  = busy_q;
        end
    endgenerate

    // Underflowing writeback means decode and writeback disagree; flag it until reset.
    assign err_d = err_q || (wb_valid && (wb_rd != 5'd0) && (cnt_wb == '0) && !flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard: registered results are queued at drive time and popped after the edge.
module tb_reg_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0, issue_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, wb_rd = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0, rd_wr = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [31:0] busy;
    logic        stall, err;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd(rd), .rd_wr(rd_wr), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .busy(busy), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          iv;
        logic [4:0]  s1;
        bit          u1;
        logic [4:0]  s2;
        bit          u2;
        logic [4:0]  d;
        bit          wr;
        bit          wbv;
        logic [4:0]  wbd;
        bit          fl;
        bit          rdy;
        logic [31:0] busy_nx;
        bit          err_nx;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] busy;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic logic [31:0] b(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    function automatic vec_t v(bit iv, logic [4:0] s1, bit u1, logic [4:0] s2, bit u2,
                               logic [4:0] d, bit wr, bit wbv, logic [4:0] wbd, bit fl,
                               bit rdy, logic [31:0] bn, bit en);
        vec_t r;
        r.iv = iv; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2; r.d = d; r.wr = wr;
        r.wbv = wbv; r.wbd = wbd; r.fl = fl; r.rdy = rdy; r.busy_nx = bn; r.err_nx = en;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t x);
        issue_valid = x.iv; rs1 = x.s1; rs1_used = x.u1; rs2 = x.s2; rs2_used = x.u2;
        rd = x.d; rd_wr = x.wr; wb_valid = x.wbv; wb_rd = x.wbd; flush = x.fl;
    endtask

    task automatic idle();
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    initial begin
        exp_t e;
        // Idle and RAW dependency on x5
        vecs.push_back(v(0, 0,0, 0,0, 0,0, 0,0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0,0, 0,0, 5,1, 0,0, 0, 1, b(5), 0));
        vecs.push_back(v(1, 5,1, 0,0, 0,0, 0,0, 0, 0, b(5), 0));
        vecs.push_back(v(1, 5,1, 0,0, 0,0, 1,5, 0, BYP, 0, 0));
        vecs.push_back(v(1, 5,1, 0,0, 0,0, 0,0, 0, 1, 0, 0));
        // x0 is never tracked
        vecs.push_back(v(1, 0,0, 0,0, 0,1, 0,0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0,1, 0,1, 0,0, 0,0, 0, 1, 0, 0));
        // Saturate x7, then issue alongside a writeback to x7, then drain three times
        vecs.push_back(v(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0));
        vecs.push_back(v(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0));
        vecs.push_back(v(1, 0,0, 0,0, 7,1, 0,0, 0, 1, b(7), 0));
        vecs.push_back(v(1, 0,0, 0,0, 7,1, 0,0, 0, 0, b(7), 0));
        vecs.push_back(v(1, 0,0, 0,0, 7,1, 1,7, 0, 1, b(7), 0));
        vecs.push_back(v(0, 0,0, 0,0, 0,0, 1,7, 0, 1, b(7), 0));
        vecs.push_back(v(0, 0,0, 0,0, 0,0, 1,7, 0, 1, b(7), 0));
        vecs.push_back(v(0, 0,0, 0,0, 0,0, 1,7, 0, 1, 0, 0));
        // Underflowing writeback on x9 sets sticky err
        vecs.push_back(v(1, 0,0, 0,0, 9,1, 0,0, 0, 1, b(9), 0));
        vecs.push_back(v(0, 0,0, 0,0, 0,0, 1,9, 0, 1, 0, 0));
        vecs.push_back(v(0, 0,0, 0,0, 0,0, 1,9, 0, 1, 0, 1));
        // Flush with pending x3/x4 and a concurrent issue of x6
        vecs.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0, 1, b(3), 1));
        vecs.push_back(v(1, 0,0, 0,0, 4,1, 0,0, 0, 1, b(3) | b(4), 1));
        vecs.push_back(v(1, 0,0, 0,0, 6,1, 0,0, 1, 1, 0, 1));
        vecs.push_back(v(1, 3,1, 4,1, 6,0, 0,0, 0, 1, 0, 1));
        // rs2 hazard, x0 writeback ignored, unused sources ignored
        vecs.push_back(v(1, 0,0, 0,0, 12,1, 0,0, 0, 1, b(12), 1));
        vecs.push_back(v(1, 12,0, 12,1, 0,0, 0,0, 0, 0, b(12), 1));
        vecs.push_back(v(1, 12,0, 12,1, 0,0, 1,0, 0, 0, b(12), 1));
        vecs.push_back(v(1, 12,0, 12,0, 0,0, 1,12, 0, 1, 0, 1));
        // Hazard with issue_valid low: not ready, but no stall
        vecs.push_back(v(1, 0,0, 0,0, 10,1, 0,0, 0, 1, b(10), 1));
        vecs.push_back(v(0, 10,1, 0,0, 0,0, 0,0, 0, 0, b(10), 1));

        // Reset state
        #2;
        check("reset_busy", busy, 32'h0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_ready", {31'd0, issue_ready}, 32'd1);
        check("reset_stall", {31'd0, stall}, 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            $display("vec %0d: iv=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d/%0d wb=%0d/%0d fl=%0d ready=%0d stall=%0d",
                     i, vecs[i].iv, vecs[i].s1, vecs[i].u1, vecs[i].s2, vecs[i].u2, vecs[i].d,
                     vecs[i].wr, vecs[i].wbv, vecs[i].wbd, vecs[i].fl, issue_ready, stall);
            check($sformatf("ready[%0d]", i), {31'd0, issue_ready}, {31'd0, vecs[i].rdy});
            check($sformatf("stall[%0d]", i), {31'd0, stall}, {31'd0, vecs[i].iv && !vecs[i].rdy});
            e.idx = i; e.busy = vecs[i].busy_nx; e.err = vecs[i].err_nx;
            sb_q.push_back(e);
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                check("queue_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("busy[%0d]", e.idx), busy, e.busy);
                check($sformatf("err[%0d]", e.idx), {31'd0, err}, {31'd0, e.err});
            end
        end

        // Asynchronous reset pulse mid-cycle with x10 pending and err set
        idle();
        #2 rst = 1'b0;
        #1;
        $display("async reset: busy=%h err=%0d", busy, err);
        check("async_busy", busy, 32'h0);
        check("async_err", {31'd0, err}, 32'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        drive(v(1, 0,0, 10,1, 0,0, 0,0, 0, 1, 0, 0));
        #2;
        $display("post-reset issue rs2=10: ready=%0d stall=%0d", issue_ready, stall);
        check("post_reset_ready", {31'd0, issue_ready}, 32'd1);
        check("post_reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("post_reset_busy", busy, 32'h0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
